// File: rtl/redmule_row_reducer_if.sv
// Row reducer bus: control, seed stream, Z input stream, result stream and status.
// Latency: none, this file only groups the wires.
// Backpressure: valid/ready on the init, in and out streams; control is pulse-based.
// Ports: slave modport = reducer side, master modport = driver/environment side.
interface redmule_row_reducer_if #(
  parameter int LANES = 16,
  parameter int BITW  = 16
);
  logic                    clear_i;
  logic                    start_i;
  logic [1:0]              op_i;
  logic [15:0]             row_len_i;
  logic                    init_en_i;
  logic                    init_valid_i;
  logic                    init_ready_o;
  logic [LANES*BITW-1:0]   init_data_i;
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [LANES*BITW-1:0]   in_data_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [LANES*BITW-1:0]   out_data_o;
  logic                    busy_o;
  logic                    is_initialized_o;
  logic                    done_o;

  modport slave (
    input  clear_i, start_i, op_i, row_len_i, init_en_i,
    input  init_valid_i, init_data_i, in_valid_i, in_data_i, out_ready_i,
    output init_ready_o, in_ready_o, out_valid_o, out_data_o,
    output busy_o, is_initialized_o, done_o
  );

  modport master (
    output clear_i, start_i, op_i, row_len_i, init_en_i,
    output init_valid_i, init_data_i, in_valid_i, in_data_i, out_ready_i,
    input  init_ready_o, in_ready_o, out_valid_o, out_data_o,
    input  busy_o, is_initialized_o, done_o
  );
endinterface

// File: rtl/redmule_row_reducer.sv
// Row reducer: folds row_len Z beats lane-wise (FP16 MAX or SUM) into one result beat.
// Latency: result valid the cycle after the last input handshake; one beat per cycle in ACCUM.
// Backpressure: out_valid_o/out_data_o held until out_ready_i; in/init ready low meanwhile.
// Ports: clk_i, rst_i (async active-high), bus (slave modport) with control, seed, Z and result
// streams plus busy/is_initialized/done status.
// Optional: define REDMULE_RED_NAN_PROP_EN to make MAX NaN-sticky instead of maxNum.
module redmule_row_reducer #(
  parameter int LANES = 16,
  parameter int BITW  = 16
) (
  input logic                  clk_i,
  input logic                  rst_i,
  redmule_row_reducer_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_INIT  = 2'd1;
  localparam logic [1:0] ST_ACCUM = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  localparam logic [1:0] RED_NONE = 2'd0;
  localparam logic [1:0] RED_MAX  = 2'd1;
  localparam logic [1:0] RED_SUM  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [15:0]           row_len_q, row_len_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [LANES*BITW-1:0] acc_q, acc_d;
  logic                  init_q, init_d;
  logic [LANES*BITW-1:0] red_res;
  logic [LANES*BITW-1:0] ident;

  // binary16 add, round-to-nearest-even. Three extra low bits (guard, round, sticky)
  // suffice: a multi-bit left renormalisation only follows a near-exact cancellation.
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y;
    logic [4:0]  ex_eff, ey_eff, d;
    logic [13:0] mx, my, mys, m;
    logic [27:0] sh;
    logic [14:0] s, r;
    logic [5:0]  e;
    logic        up, a_nan, b_nan, a_inf, b_inf;
    a_nan = (a[14:10] == 5'h1f) && (a[9:0] != 10'h0);
    b_nan = (b[14:10] == 5'h1f) && (b[9:0] != 10'h0);
    a_inf = (a[14:0] == 15'h7c00);
    b_inf = (b[14:0] == 15'h7c00);
    if (a_nan || b_nan) return 16'h7e00;
    if (a_inf && b_inf && (a[15] != b[15])) return 16'h7e00;
    if (a_inf) return a;
    if (b_inf) return b;
    if ((a[14:0] == 15'h0) && (b[14:0] == 15'h0)) return {a[15] & b[15], 15'h0};
    // x carries the larger magnitude, so it also carries the result sign
    if (b[14:0] > a[14:0]) begin x = b; y = a; end
    else begin x = a; y = b; end
    ex_eff = (x[14:10] == 5'h0) ? 5'd1 : x[14:10];
    ey_eff = (y[14:10] == 5'h0) ? 5'd1 : y[14:10];
    mx = {x[14:10] != 5'h0, x[9:0], 3'b000};
    my = {y[14:10] != 5'h0, y[9:0], 3'b000};
    d  = ex_eff - ey_eff;
    if (d > 5'd15) d = 5'd15;
    sh  = {my, 14'h0} >> d;
    mys = sh[27:14] | {13'h0, |sh[13:0]};
    if (x[15] == y[15]) s = {1'b0, mx} + {1'b0, mys};
    else                s = {1'b0, mx} - {1'b0, mys};
    if (s == 15'h0) return 16'h0000;
    e = {1'b0, ex_eff};
    if (s[14]) begin
      m = s[14:1] | {13'h0, s[0]};
      e = e + 6'd1;
    end else begin
      m = s[13:0];
      for (int k = 0; k < 13; k++) begin
        if (!m[13] && (e > 6'd1)) begin
          m = m << 1;
          e = e - 6'd1;
        end
      end
    end
    if (e >= 6'd31) return {x[15], 15'h7c00};
    up = m[2] & (m[3] | m[1] | m[0]);
    // a rounding carry ripples naturally into the exponent (denormal->normal, max->inf)
    r = {(m[13] ? e[4:0] : 5'd0), m[12:3]} + {14'h0, up};
    return {x[15], r};
  endfunction

  function automatic logic [15:0] fp16_max(input logic [15:0] a, input logic [15:0] b);
    logic        a_nan, b_nan;
    logic [15:0] ka, kb;
    a_nan = (a[14:10] == 5'h1f) && (a[9:0] != 10'h0);
    b_nan = (b[14:10] == 5'h1f) && (b[9:0] != 10'h0);
`ifdef REDMULE_RED_NAN_PROP_EN
    if (a_nan || b_nan) return 16'h7e00;
`else
    if (a_nan && b_nan) return 16'h7e00;
    if (a_nan) return b;
    if (b_nan) return a;
`endif
    // monotonic integer key: orders -inf..-0 < +0..+inf
    ka = a[15] ? ~a : {1'b1, a[14:0]};
    kb = b[15] ? ~b : {1'b1, b[14:0]};
    return (kb > ka) ? b : a;
  endfunction

  always_comb begin
    red_res = acc_q;
    ident   = '0;
    for (int l = 0; l < LANES; l++) begin
      if (op_q == RED_SUM)
        red_res[l*BITW +: BITW] = fp16_add(acc_q[l*BITW +: BITW], bus.in_data_i[l*BITW +: BITW]);
      else
        red_res[l*BITW +: BITW] = fp16_max(acc_q[l*BITW +: BITW], bus.in_data_i[l*BITW +: BITW]);
      ident[l*BITW +: BITW] = (bus.op_i == RED_SUM) ? 16'h0000 : 16'hfc00;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    row_len_d = row_len_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    init_d    = init_q;
    if (bus.clear_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      acc_d   = '0;
      init_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start_i && ((bus.op_i == RED_MAX) || (bus.op_i == RED_SUM))) begin
            op_d      = bus.op_i;
            row_len_d = bus.row_len_i;
            cnt_d     = '0;
            if (bus.init_en_i) begin
              state_d = ST_INIT;
            end else begin
              acc_d   = ident;
              init_d  = 1'b1;
              state_d = (bus.row_len_i == 16'h0) ? ST_OUT : ST_ACCUM;
            end
          end
        end
        ST_INIT: begin
          if (bus.init_valid_i) begin
            acc_d   = bus.init_data_i;
            init_d  = 1'b1;
            state_d = (row_len_q == 16'h0) ? ST_OUT : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (bus.in_valid_i) begin
            acc_d = red_res;
            if (cnt_q == row_len_q - 16'd1) begin
              state_d = ST_OUT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
        default: begin
          if (bus.out_ready_i) begin
            init_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      op_q      <= RED_NONE;
      row_len_q <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      init_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      row_len_q <= row_len_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      init_q    <= init_d;
    end
  end

  assign bus.init_ready_o     = (state_q == ST_INIT);
  assign bus.in_ready_o       = (state_q == ST_ACCUM);
  assign bus.out_valid_o      = (state_q == ST_OUT);
  assign bus.out_data_o       = acc_q;
  assign bus.busy_o           = (state_q != ST_IDLE);
  assign bus.is_initialized_o = init_q;
  // a clear in the handshake cycle cancels delivery, so it also suppresses done
  assign bus.done_o           = (state_q == ST_OUT) && bus.out_ready_i && !bus.clear_i;

endmodule

// File: doc/redmule_row_reducer.md
Name: redmule_row_reducer

Overview:
- Reduction stage directly downstream of the Z buffer.
- Consumes Z output beats of LANES FP16 values each and folds ROW_LEN consecutive beats lane-wise with MAX or SUM, optionally seeded with initialisation values fetched from R_ADDR.
- Emits one reduced beat toward the R sink streamer.
- Driven by the cntrl_red_t fields (row_len, op, load, enable) and reports flgs_red_t.is_initialized.

Parameters:
- LANES, 16, FP16 elements per beat.
- BITW, 16, element width (FP16 only).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- clear_i  in  1  synchronous clear; returns to IDLE, drops all data
- start_i  in  1  one-cycle pulse; latches op_i, row_len_i, init_en_i
- op_i  in  2  red_op_t: RED_NONE=0, MAX=1, SUM=2
- row_len_i  in  16  input beats per reduction
- init_en_i  in  1  1: take seed beat from init stream; 0: seed with identity
- init_valid_i / init_ready_o  in/out  1  seed stream handshake
- init_data_i  in  LANES*BITW  seed values
- in_valid_i / in_ready_o  in/out  1  Z beat handshake
- in_data_i  in  LANES*BITW  Z beat, lane i at [16i+15:16i]
- out_valid_o / out_ready_i  out/in  1  result handshake
- out_data_o  out  LANES*BITW  reduced beat
- busy_o  out  1  high in any state other than IDLE
- is_initialized_o  out  1  accumulator seeded, result not yet delivered
- done_o  out  1  one-cycle pulse on output handshake

Behaviour:
- Reset values:
  - All outputs 0; out_data_o 0.
  - State IDLE; accumulator 0; beat counter 0.
- States and transitions:
  - IDLE: in_ready_o=0, init_ready_o=0. On start_i:
    - op_i=RED_NONE: start ignored, remain IDLE.
    - init_en_i=1: go to INIT.
    - init_en_i=0: accumulator <= identity in every lane, is_initialized_o<=1, go to ACCUM, or to OUT if row_len_i=0.
  - INIT: init_ready_o=1. On init handshake: accumulator <= init_data_i, is_initialized_o<=1, go to ACCUM, or to OUT if row_len=0.
  - ACCUM: in_ready_o=1, one beat per cycle, no bubbles.
    - Each handshake: acc[i] <= f(acc[i], in[i]) and the counter increments.
    - On the handshake where the counter reaches row_len-1: go to OUT, counter <= 0.
  - OUT: out_valid_o=1, out_data_o=accumulator; both held stable until out_ready_i.
    - On handshake: done_o pulses, is_initialized_o<=0, go to IDLE.
- Identity values: SUM +0 (0x0000); MAX -inf (0xFC00).
- Latency:
  - Last input handshake at cycle t gives out_valid_o at t+1.
  - An out_ready_i already high completes at t+1.
  - Next start_i accepted the cycle after done_o.
- Arithmetic, combinational and registered into the accumulator:
  - SUM: IEEE-754 binary16 add, RNE; NaN in gives canonical NaN 0x7E00; overflow gives ±inf.
  - MAX: IEEE maxNum.
    - One operand NaN: return the other. Both NaN: 0x7E00.
    - +0 > -0. Denormals ordered normally.
- start_i while busy_o=1 is ignored.
- clear_i has priority over every handshake in the same cycle. clear_i together with start_i: clear wins.
- row_len is latched at start; row_len_i changes mid-operation have no effect.
- Handshakes follow valid/ready: a producer never drops valid before ready; data is sampled only when valid & ready.
- rst_i mid-operation: immediate return to reset values; in-flight partial result lost; no done_o.

Optional Feature:
- Macro: REDMULE_RED_NAN_PROP_EN.
- Defined: MAX propagates NaN; any NaN operand makes that lane 0x7E00 for the rest of the reduction.
- Undefined: maxNum semantics as in Behaviour.
- SUM unaffected either way.

Test Plan:
- SUM without seed:
  - Stimulus: start op=SUM, row_len=3, init_en=0; lane0 beats 0x3C00, 0x4000, 0x4200 (1, 2, 3).
  - Required: out lane0=0x4600 (6.0), valid 1 cycle after last beat; done_o one pulse.
- MAX with seed:
  - Stimulus: init_en=1, seed all lanes 0x4400 (4.0); row_len=2; lane5 beats 0x4500, 0xC800.
  - Required: lane5=0x4500, other lanes (zero beats)=0x4400, is_initialized_o high from seed handshake until output.
- row_len=0:
  - Stimulus: op=MAX, init_en=0.
  - Required: out all lanes 0xFC00, in_ready_o never asserted.
- Backpressure:
  - Stimulus: out_ready_i low 5 cycles.
  - Required: out_valid_o and out_data_o stable; in_ready_o=0; a second start_i is ignored.
- NaN:
  - Stimulus: MAX beats 0x7E00 then 0x3C00.
  - Required: 0x3C00 without the macro; 0x7E00 with REDMULE_RED_NAN_PROP_EN.
- Interruptions:
  - clear_i, then separately rst_i, asserted after 2 of 8 beats.
  - Required: busy_o=0 next cycle (immediately for rst_i); no done_o; a fresh reduction then produces the correct result.
